// File: rtl/datapath_pkg.sv
// Shared types and sizing constants for the dispatch scoreboard slice.
package datapath_pkg;
  typedef enum logic [1:0] {
    FU_S_T = 2'd0,
    FU_M_T = 2'd1,
    FU_G_T = 2'd2
  } fu_type_t;

  localparam int NSREG    = 32;
  localparam int NMREG    = 16;
  localparam int GEMM_MAX = 2;
endpackage

// File: rtl/sb_busy_table.sv
// One-bit-per-register busy table; a set and a clear hitting the same bit resolve to set.
module sb_busy_table #(
  parameter int W  = 32,
  parameter int IW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_set,
  input  logic [IW-1:0] i_set_idx,
  input  logic          i_clr,
  input  logic [IW-1:0] i_clr_idx,
  output logic [W-1:0]  o_busy
);
  logic [W-1:0] r_busy;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)
          r_busy[gi] <= 1'b0;
        else if (i_set && (i_set_idx == IW'(gi)))
          r_busy[gi] <= 1'b1;
        else if (i_clr && (i_clr_idx == IW'(gi)))
          r_busy[gi] <= 1'b0;
      end
    end
  endgenerate

  assign o_busy = r_busy;
endmodule

// File: rtl/dispatch_scoreboard.sv
// In-order dispatch gate: blocks on RAW/WAW against registered busy tables,
// unit readiness and the outstanding-GEMM limit.
module dispatch_scoreboard
  import datapath_pkg::*;
#(
  parameter int NSREG    = datapath_pkg::NSREG,
  parameter int NMREG    = datapath_pkg::NMREG,
  parameter int GEMM_MAX = datapath_pkg::GEMM_MAX
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        d_valid,
  input  fu_type_t    d_fu_t,
  input  logic [4:0]  d_s_rs1,
  input  logic [4:0]  d_s_rs2,
  input  logic [4:0]  d_s_rd,
  input  logic        d_s_reg_write,
  input  logic [3:0]  d_m_rs1,
  input  logic [3:0]  d_m_rs2,
  input  logic [3:0]  d_m_rs3,
  input  logic [3:0]  d_m_rd,
  input  logic [2:0]  d_m_use,
  input  logic        d_m_reg_write,
  input  logic        s_fu_ready,
  input  logic        m_fu_ready,
  input  logic        s_wb_valid,
  input  logic [4:0]  s_wb_rd,
  input  logic        m_wb_valid,
  input  logic [3:0]  m_wb_rd,
  input  logic        g_done,
  output logic        d_ready,
  output logic        issue_s,
  output logic        issue_m,
  output logic        issue_g,
  output logic [31:0] stall_cnt
);
  localparam int GW = $clog2(GEMM_MAX + 1);

  logic [NSREG-1:0] w_s_busy;
  logic [NMREG-1:0] w_m_busy;
  logic [GW-1:0]    r_gemm_cnt;
  logic [31:0]      r_stall_cnt;
  logic             w_s_src_haz, w_m_src_haz, w_waw, w_unit_ok, w_fire, w_g_dec;

  // GEMMs have no scalar operands; loads/stores read base and stride.
  assign w_s_src_haz = (d_fu_t != FU_G_T) &&
                       (((d_s_rs1 != 5'd0) && w_s_busy[d_s_rs1]) ||
                        ((d_s_rs2 != 5'd0) && w_s_busy[d_s_rs2]));
  assign w_m_src_haz = (d_m_use[0] && w_m_busy[d_m_rs1]) ||
                       (d_m_use[1] && w_m_busy[d_m_rs2]) ||
                       (d_m_use[2] && w_m_busy[d_m_rs3]);
  assign w_waw = (d_s_reg_write && (d_s_rd != 5'd0) && w_s_busy[d_s_rd]) ||
                 (d_m_reg_write && w_m_busy[d_m_rd]);

  always_comb begin
    w_unit_ok = 1'b0;
    case (d_fu_t)
      FU_S_T:  w_unit_ok = s_fu_ready;
      FU_M_T:  w_unit_ok = m_fu_ready;
      FU_G_T:  w_unit_ok = (r_gemm_cnt < GW'(GEMM_MAX));
      default: w_unit_ok = 1'b0;
    endcase
  end

  assign d_ready   = !w_s_src_haz && !w_m_src_haz && !w_waw && w_unit_ok;
  assign w_fire    = d_valid && d_ready;
  assign issue_s   = w_fire && (d_fu_t == FU_S_T);
  assign issue_m   = w_fire && (d_fu_t == FU_M_T);
  assign issue_g   = w_fire && (d_fu_t == FU_G_T);
  assign w_g_dec   = g_done && (r_gemm_cnt != '0);
  assign stall_cnt = r_stall_cnt;

  sb_busy_table #(.W(NSREG), .IW(5)) u_s_table (
    .CLK      (CLK),
    .RST      (RST),
    .i_set    (w_fire && d_s_reg_write && (d_s_rd != 5'd0)),
    .i_set_idx(d_s_rd),
    .i_clr    (s_wb_valid),
    .i_clr_idx(s_wb_rd),
    .o_busy   (w_s_busy)
  );

  sb_busy_table #(.W(NMREG), .IW(4)) u_m_table (
    .CLK      (CLK),
    .RST      (RST),
    .i_set    (w_fire && d_m_reg_write),
    .i_set_idx(d_m_rd),
    .i_clr    (m_wb_valid),
    .i_clr_idx(m_wb_rd),
    .o_busy   (w_m_busy)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gemm_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (issue_g && !w_g_dec)
        r_gemm_cnt <= r_gemm_cnt + 1'b1;
      else if (w_g_dec && !issue_g)
        r_gemm_cnt <= r_gemm_cnt - 1'b1;
      if (d_valid && !d_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
endmodule
